seq_shifter: RTL



---
 rtl/seq_shifter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle sll/srl/sra shift unit for the ALU execute stage.
// The unit shifts by at most STEP bit positions per cycle. It uses a
// start/busy/done handshake with the stall logic.
// Optional feature: define SEQ_SHIFTER_ROTATE_EN to make op=2'b11 a rotate-left.
// Without that macro, op=2'b11 is decoded as sll.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(WIDTH);
  // STEP <= WIDTH/2, so it always fits in the SW-bit remaining-amount field.
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic             sign_q, sign_d;

  logic [SW-1:0]    k;
  logic [WIDTH-1:0] shl, shr, fill_mask, shifted;

  // The amount is masked to SW bits, so the upper shamt bits are
  // intentionally left unused.
  logic shamt_unused;
  assign shamt_unused = ^shamt[WIDTH-1:SW];

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [SW:0] rot_amt;
`endif

  // One shift step: move by k = min(STEP, rem) and fill the vacated bits according to op_q.
  always_comb begin
    k         = (rem_q < STEP_W) ? rem_q : STEP_W;
    shl       = data_q << k;
    shr       = data_q >> k;
    fill_mask = ~({WIDTH{1'b1}} >> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
    // k >= 1 in SHIFT, so the wrap-around amount stays within 1..WIDTH-1.
    rot_amt   = (SW+1)'(WIDTH) - {1'b0, k};
`endif
    unique case (op_q)
      2'b00:   shifted = shl;
      2'b01:   shifted = shr;
      2'b10:   shifted = shr | (sign_q ? fill_mask : '0);
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11:   shifted = shl | (data_q >> rot_amt);
`else
      2'b11:   shifted = shl;
`endif
      default: shifted = shl;
    endcase
  end

  // Next-state logic for the IDLE/SHIFT/DONE sequencer and its datapath registers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. This
    // prevents latches on paths that do not assign it.
    state_d  = state_q;
    data_d   = data_q;
    op_d     = op_q;
    rem_d    = rem_q;
    sign_d   = sign_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d = a;
          op_d   = op;
          rem_d  = shamt[SW-1:0];
          sign_d = a[WIDTH-1];
          if (rem_d == '0) begin
            state_d  = S_DONE;
            result_d = a;
          end else begin
            state_d  = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - k;
        if (rem_d == '0) begin
          state_d  = S_DONE;
          result_d = shifted;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with a synchronous, active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. This
    // makes every register sample the pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      result_q <= '0;
      op_q     <= 2'b00;
      rem_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      sign_q   <= sign_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
